// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  function automatic int bit_clks(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the serial line plus falling-edge detect on the synced value.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rxs,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  // Flops reset to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxs  = sync_q;
  assign fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_majority.sv
// 8N1 UART receiver with 3-sample majority voting, glitch-start rejection and framing check.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx_majority
  import uart_pkg::*;
#(
  parameter int clk_freq  = 1000000,
  parameter int baud_rate = 9600
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 done,
  output logic                 ferr,
  output logic                 perr,
  output logic                 busy
);

  localparam int BIT_CLKS = bit_clks(clk_freq, baud_rate);
  localparam int HALF     = BIT_CLKS / 2;
  localparam int CW       = $clog2(BIT_CLKS);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CLKS - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC  = CW'(HALF + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  if (BIT_CLKS < 8) begin : g_bit_clks_check
    $error("uart_rx_majority: clk_freq/baud_rate must be at least 8");
  end

  rx_state_t            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic [1:0]           smp_q, smp_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;
  logic                 busy_q, busy_d;
  logic                 rxs, fall, maj, dec, bit_end, stop_ok;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d;
  logic                 pbad_q, pbad_d;
  logic                 perr_q, perr_d;
`endif

  uart_rx_sync u_sync (
    .clk  (clk),
    .rst  (rst),
    .rx   (rx),
    .rxs  (rxs),
    .fall (fall)
  );

  // The third sample is the live synced value, so the vote resolves on the decision cycle.
  assign maj     = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);
  assign dec     = (cnt_q == CNT_DEC);
  assign bit_end = (cnt_q == CNT_LAST);
`ifdef UART_RX_PARITY_EN
  assign stop_ok = maj & ~pbad_q;
`else
  assign stop_ok = maj;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    dout_d  = dout_q;
    smp_d   = smp_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = busy_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    pbad_d  = pbad_q;
    perr_d  = 1'b0;
`endif
    if (cnt_q == CNT_S0) smp_d[0] = rxs;
    if (cnt_q == CNT_S1) smp_d[1] = rxs;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = START;
          busy_d  = 1'b1;
          idx_d   = '0;
`ifdef UART_RX_PARITY_EN
          par_d   = 1'b0;
          pbad_d  = 1'b0;
`endif
        end
      end
      START: begin
        if (dec && maj) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end else if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (dec) begin
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
          par_d   = par_q ^ maj;
`endif
        end
        if (bit_end) begin
          idx_d = idx_q + IW'(1);
          if (idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (dec) pbad_d = par_q ^ maj;
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Leave at the stop-bit centre so a following start edge is not missed.
        if (dec) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          ferr_d  = ~maj;
`ifdef UART_RX_PARITY_EN
          perr_d  = pbad_q;
`endif
          if (stop_ok) begin
            dout_d = shift_q;
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      smp_q   <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      pbad_q  <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      smp_q   <= smp_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      pbad_q  <= pbad_d;
      perr_q  <= perr_d;
`endif
    end
  end

  assign dout = dout_q;
  assign done = done_q;
  assign ferr = ferr_q;
  assign busy = busy_q;
`ifdef UART_RX_PARITY_EN
  assign perr = perr_q;
`else
  assign perr = 1'b0;
`endif

endmodule
